// File: rtl/slave1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// slave1 -- SPI slave, one 8-bit frame, MSB first, compile-time SPI mode.
//
// SCLK, CS and MOSI come from an external master and are asynchronous to CLK.
// Each one goes through the same two-flop synchroniser, so their relative
// ordering is kept. A third SCLK stage supplies the previous level for edge
// detection. The block shifts data_in out on MISO, assembles the received
// byte into rx, and pulses done once per completed frame.
//
// Parameters
//   mode     {CPOL, CPHA}. CPOL is the SCLK idle level. CPHA = 0 samples on
//            the leading edge, CPHA = 1 samples on the trailing edge.
//
// Ports
//   CLK      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   MOSI     in   1  serial data from master (asynchronous)
//   SCLK     in   1  SPI clock from master (asynchronous)
//   CS       in   1  chip select, active low (asynchronous)
//   data_in  in   8  byte to transmit, taken until the first sample of a frame
//   MISO     out  1  serial data to master, MSB first, 0 while deselected
//   done     out  1  one-CLK pulse when the 8th bit has been sampled
//   rx       out  8  last completed received byte
// -----------------------------------------------------------------------------
module slave1 #(
    parameter logic [1:0] mode = 2'd2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       MOSI,
    input  logic       SCLK,
    input  logic       CS,
    input  logic [7:0] data_in,
    output logic       MISO,
    output logic       done,
    output logic [7:0] rx
);

    localparam logic CPOL = mode[1];
    localparam logic CPHA = mode[0];

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser stages. Index 0 is the first flop after the pin.
    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    state_t     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] tx_q,       tx_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_q,       rx_d;
    logic       done_q,     done_d;

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;

    // ---- stage 0-2: input synchronisers ------------------------------------
    // The SCLK stages reset to the idle level so leaving reset never looks
    // like an edge. CS stages reset to "deselected" so MISO stays quiet while
    // the real CS level propagates through.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sclk_sync_q <= {3{CPOL}};
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            cs_sync_q   <= {cs_sync_q[0], CS};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
        end
    end

    // ---- edge classification -----------------------------------------------
    // Stage 1 is the "current" synced level, stage 2 the previous one. MOSI
    // stage 1 lines up with SCLK stage 1, so a sample edge sees the data bit
    // that was on the pin when the edge happened.
    assign lead_edge   = (sclk_sync_q[2] == CPOL) && (sclk_sync_q[1] != CPOL);
    assign trail_edge  = (sclk_sync_q[2] != CPOL) && (sclk_sync_q[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    // ---- state and datapath registers --------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 8'h00;
            rx_shift_q <= 7'h00;
            rx_q       <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_q       <= rx_d;
            done_q     <= done_d;
        end
    end

    // ---- next-state and datapath logic -------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_d       = rx_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_sync_q[1]) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_sync_q[1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decisions follow the synced CS directly (state_d) so that an abort
        // takes effect in the same cycle CS is seen high, together with the
        // SCLK edges of that cycle.
        if (state_d == ST_IDLE) begin
            // Deselected, or a frame aborted: forget partial progress but
            // leave rx alone.
            bit_cnt_d = 3'd0;
            tx_d      = data_in;
        end else if (sample_edge) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_sync_q[1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_d   = {rx_shift_q, mosi_sync_q[1]};
                done_d = 1'b1;
            end
        end else if (bit_cnt_q == 3'd0) begin
            // No bit of the current frame sampled yet: keep tracking data_in.
            // Any shift edge seen here is ignored, which covers both the
            // first leading edge in CPHA=1 and the trailing edge that follows
            // the 8th sample in CPHA=0, so the new MSB stays presented.
            tx_d = data_in;
        end else if (shift_edge) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    // ---- outputs -----------------------------------------------------------
    assign MISO = (state_q == ST_ACTIVE) ? tx_q[7] : 1'b0;
    assign done = done_q;
    assign rx   = rx_q;

endmodule

// File: tb/tb_slave1.sv
`timescale 1ns/1ps
// Testbench for slave1: one instance per SPI mode, each with its own SCLK, CS
// and MOSI, sharing CLK, reset and data_in. A small SPI master task drives
// frames at the pins; expected values come from the bytes the bench sends.
module tb_slave1;

    logic       CLK;
    logic       reset;
    logic [7:0] data_in;
    logic       sclk   [4];
    logic       cs     [4];
    logic       mosi   [4];
    logic       miso_w [4];
    logic       done_w [4];
    logic [7:0] rx_w   [4];

    int checks = 0;
    int errors = 0;
    int done_cnt [4];
    logic [7:0] model_rx [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        slave1 #(.mode(2'(g))) u_dut (
            .CLK     (CLK),
            .reset   (reset),
            .MOSI    (mosi[g]),
            .SCLK    (sclk[g]),
            .CS      (cs[g]),
            .data_in (data_in),
            .MISO    (miso_w[g]),
            .done    (done_w[g]),
            .rx      (rx_w[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count CLK cycles with done high; a pulse wider than one cycle shows up
    // as an extra count.
    initial for (int k = 0; k < 4; k++) done_cnt[k] = 0;
    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Clock nbits bits on instance m. CPHA=0: MOSI set, wait, sample edge
    // (leading), wait, trailing edge. CPHA=1: leading edge with MOSI change,
    // wait, sample edge (trailing), wait. MISO is read just before each
    // sample edge.
    task automatic frame_bits(input int m, input logic [7:0] mo, input int nbits,
                              input int h, output logic [7:0] mi);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = mo[7-i];
                #h;
                mi[7-i] = miso_w[m];
                sclk[m] = ~cpol;
                #h;
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = mo[7-i];
                #h;
                mi[7-i] = miso_w[m];
                sclk[m] = cpol;
                #h;
            end
        end
    endtask

    // Full CS-framed transfer. With late set, data_in holds a wrong byte when
    // CS falls and the real one arrives shortly after.
    task automatic frame(input int m, input logic [7:0] mo, input logic [7:0] din,
                         input bit late, input int nbits, input int h,
                         output logic [7:0] mi);
        @(posedge CLK);
        #2;
        data_in = late ? ~din : din;
        cs[m] = 1'b0;
        #10;
        data_in = din;
        #h;
        frame_bits(m, mo, nbits, h, mi);
        if (m % 2 == 0) #h;
        cs[m] = 1'b1;
        #60;
    endtask

    typedef struct {
        int         m;
        logic [7:0] mo;
        logic [7:0] din;
        bit         late;
        int         nbits;
        int         h;
        logic [7:0] exp_rx;
        int         exp_done;
        bit         chk_mi;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        logic [7:0] mask;
        int         base;
        int         m;
        logic [7:0] mo;
        logic [7:0] din;
        int         nb;

        reset   = 1'b1;
        data_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            sclk[k]     = (k >= 2);
            cs[k]       = 1'b1;
            mosi[k]     = 1'b0;
            model_rx[k] = 8'h00;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_rx_m%0d", k),   rx_w[k],   8'h00);
            chk($sformatf("reset_done_m%0d", k), done_w[k], 1'b0);
            chk($sformatf("reset_miso_m%0d", k), miso_w[k], 1'b0);
        end
        reset = 1'b0;
        repeat (4) @(posedge CLK);

        //          m  mosi    din    late nb  h   exp_rx done chk_mi
        tbl[0] = '{2, 8'hB2, 8'h00, 1'b0, 8, 10, 8'hB2, 1, 1'b0};
        tbl[1] = '{2, 8'hB2, 8'hB3, 1'b1, 8, 40, 8'hB2, 1, 1'b1};
        tbl[2] = '{0, 8'h5A, 8'h5A, 1'b0, 8, 40, 8'h5A, 1, 1'b1};
        tbl[3] = '{1, 8'h5A, 8'h5A, 1'b0, 8, 40, 8'h5A, 1, 1'b1};
        tbl[4] = '{2, 8'h5A, 8'h5A, 1'b0, 8, 40, 8'h5A, 1, 1'b1};
        tbl[5] = '{3, 8'h5A, 8'h5A, 1'b0, 8, 40, 8'h5A, 1, 1'b1};
        tbl[6] = '{2, 8'hFF, 8'hC3, 1'b0, 4, 40, 8'h5A, 0, 1'b1};
        tbl[7] = '{2, 8'h3C, 8'h3C, 1'b0, 8, 40, 8'h3C, 1, 1'b1};

        for (int v = 0; v < 8; v++) begin
            base = done_cnt[tbl[v].m];
            frame(tbl[v].m, tbl[v].mo, tbl[v].din, tbl[v].late, tbl[v].nbits, tbl[v].h, mi);
            chk($sformatf("tbl%0d_rx", v), rx_w[tbl[v].m], tbl[v].exp_rx);
            chk($sformatf("tbl%0d_done", v), done_cnt[tbl[v].m] - base, tbl[v].exp_done);
            if (tbl[v].chk_mi) begin
                mask = 8'hFF << (8 - tbl[v].nbits);
                chk($sformatf("tbl%0d_miso", v), mi & mask, tbl[v].din & mask);
            end
            model_rx[tbl[v].m] = rx_w[tbl[v].m] === tbl[v].exp_rx ? tbl[v].exp_rx : tbl[v].exp_rx;
        end

        // Two bytes back to back under one CS (mode 2).
        base = done_cnt[2];
        @(posedge CLK);
        #2;
        data_in = 8'hA5;
        cs[2] = 1'b0;
        #50;
        frame_bits(2, 8'hA5, 8, 40, mi);
        chk("b2b_rx1", rx_w[2], 8'hA5);
        chk("b2b_done1", done_cnt[2] - base, 1);
        data_in = 8'h0F;
        frame_bits(2, 8'h0F, 8, 40, mi2);
        #40;
        cs[2] = 1'b1;
        #60;
        chk("b2b_rx2", rx_w[2], 8'h0F);
        chk("b2b_done2", done_cnt[2] - base, 2);
        chk("b2b_miso1", mi, 8'hA5);
        chk("b2b_miso2", mi2, 8'h0F);
        model_rx[2] = 8'h0F;

        // Reset in the middle of a frame, then a clean frame.
        @(posedge CLK);
        #2;
        data_in = 8'h77;
        cs[2] = 1'b0;
        #50;
        frame_bits(2, 8'hFF, 4, 40, mi);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_mid_rx", rx_w[2], 8'h00);
        chk("rst_mid_done", done_w[2], 1'b0);
        chk("rst_mid_miso", miso_w[2], 1'b0);
        reset = 1'b0;
        cs[2] = 1'b1;
        for (int k = 0; k < 4; k++) model_rx[k] = 8'h00;
        #60;
        base = done_cnt[2];
        frame(2, 8'h69, 8'h96, 1'b0, 8, 40, mi);
        chk("rst_after_rx", rx_w[2], 8'h69);
        chk("rst_after_done", done_cnt[2] - base, 1);
        chk("rst_after_miso", mi, 8'h96);
        model_rx[2] = 8'h69;

        // Random frames against the reference model: a full frame delivers
        // the master's byte and one done pulse, an aborted one changes
        // nothing; MISO carries data_in's bits in MSB-first order.
        for (int r = 0; r < 16; r++) begin
            m   = $urandom_range(0, 3);
            mo  = 8'($urandom);
            din = 8'($urandom);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            base = done_cnt[m];
            frame(m, mo, din, 1'($urandom_range(0, 1)), nb, 40, mi);
            if (nb == 8) model_rx[m] = mo;
            chk($sformatf("rnd%0d_m%0d_rx", r, m), rx_w[m], model_rx[m]);
            chk($sformatf("rnd%0d_m%0d_done", r, m), done_cnt[m] - base, (nb == 8) ? 1 : 0);
            mask = 8'hFF << (8 - nb);
            chk($sformatf("rnd%0d_m%0d_miso", r, m), mi & mask, din & mask);
        end

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("final_rx_m%0d", k), rx_w[k], model_rx[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
